// File: rtl/regfile_nport.sv
// ---------------------------------------------------------------------------
// regfile_nport
// Multi-read-port, single-write-port register file for the RV32 core.
// Register 0 (x0) is hard-wired to zero. Same-cycle write data can optionally
// be forwarded to matching reads, and reads can optionally be registered, in
// which case a per-port valid follows the request by one cycle.
//
// Ports:
//   clk    in   1          rising-edge clock
//   rst    in   1          asynchronous active-high reset
//   we     in   1          write enable
//   waddr  in   AW         write register index
//   wdata  in   XLEN       write data
//   re     in   NRD        per-port read request
//   raddr  in   NRD*AW     read indices, port i = raddr[i*AW +: AW]
//   rdata  out  NRD*XLEN   read data, port i = rdata[i*XLEN +: XLEN]
//   rvalid out  NRD        per-port read data valid
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module regfile_nport #(
   parameter int XLEN       = 32,
   parameter int AW         = 5,
   parameter int NRD        = 2,
   parameter int BYPASS     = 1,
   parameter int RD_LATENCY = 0
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                we,
   input  logic [AW-1:0]       waddr,
   input  logic [XLEN-1:0]     wdata,
   input  logic [NRD-1:0]      re,
   input  logic [NRD*AW-1:0]   raddr,
   output logic [NRD*XLEN-1:0] rdata,
   output logic [NRD-1:0]      rvalid
);

   localparam int NREGS = 2**AW;

   logic [XLEN-1:0]     mem [NREGS];
   logic [NRD*XLEN-1:0] sel_p0;

   // Register array. Entry 0 is cleared by reset and never written, so it
   // stays zero; the read select also forces zero for index 0.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NREGS; i++) begin
            mem[i] <= '0;
         end
      end else if (we && (waddr != '0)) begin
         mem[waddr] <= wdata;
      end
   end

   // Stage p0: per-port read select (x0 first, then optional forward, then array)
   for (genvar g = 0; g < NRD; g++) begin : g_sel
      logic [AW-1:0] ra;
      logic          fwd;
      assign ra  = raddr[g*AW +: AW];
      assign fwd = (BYPASS != 0) && we && (waddr == ra);
      assign sel_p0[g*XLEN +: XLEN] = (ra == '0) ? '0 :
                                      fwd        ? wdata : mem[ra];
   end

   if (RD_LATENCY == 0) begin : g_comb
      assign rdata  = sel_p0;
      assign rvalid = re;
   end else begin : g_reg
      logic [NRD*XLEN-1:0] rdata_p1;
      logic [NRD-1:0]      vld_p1;

      // Stage p1: capture on request; data holds when the port is idle
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            rdata_p1 <= '0;
            vld_p1   <= '0;
         end else begin
            vld_p1 <= re;
            for (int i = 0; i < NRD; i++) begin
               if (re[i]) begin
                  rdata_p1[i*XLEN +: XLEN] <= sel_p0[i*XLEN +: XLEN];
               end
            end
         end
      end

      assign rdata  = rdata_p1;
      assign rvalid = vld_p1;
   end

endmodule

// File: tb/tb_regfile_nport.sv
// ---------------------------------------------------------------------------
// tb_regfile_nport
// Drives four regfile_nport instances (every BYPASS x RD_LATENCY combination)
// from one shared stimulus stream and compares them against a behavioural
// array model every cycle, plus directed literal expectations.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_regfile_nport;

   localparam int XLEN  = 32;
   localparam int AW    = 4;
   localparam int NRD   = 2;
   localparam int NCFG  = 4;
   localparam int NREGS = 2**AW;

   logic                clk = 1'b0;
   logic                rst = 1'b0;
   logic                we;
   logic [AW-1:0]       waddr;
   logic [XLEN-1:0]     wdata;
   logic [NRD-1:0]      re;
   logic [NRD*AW-1:0]   raddr;
   logic [NRD*XLEN-1:0] rd_c [NCFG];
   logic [NRD-1:0]      rv_c [NCFG];

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   // u0: bypass/comb, u1: no bypass/comb, u2: bypass/registered, u3: no bypass/registered
   regfile_nport #(.XLEN(XLEN), .AW(AW), .NRD(NRD), .BYPASS(1), .RD_LATENCY(0)) u0 (
      .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
      .re(re), .raddr(raddr), .rdata(rd_c[0]), .rvalid(rv_c[0]));
   regfile_nport #(.XLEN(XLEN), .AW(AW), .NRD(NRD), .BYPASS(0), .RD_LATENCY(0)) u1 (
      .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
      .re(re), .raddr(raddr), .rdata(rd_c[1]), .rvalid(rv_c[1]));
   regfile_nport #(.XLEN(XLEN), .AW(AW), .NRD(NRD), .BYPASS(1), .RD_LATENCY(1)) u2 (
      .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
      .re(re), .raddr(raddr), .rdata(rd_c[2]), .rvalid(rv_c[2]));
   regfile_nport #(.XLEN(XLEN), .AW(AW), .NRD(NRD), .BYPASS(0), .RD_LATENCY(1)) u3 (
      .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
      .re(re), .raddr(raddr), .rdata(rd_c[3]), .rvalid(rv_c[3]));

   function automatic bit cfg_byp(int k);
      return (k == 0) || (k == 2);
   endfunction

   function automatic bit cfg_lat(int k);
      return (k >= 2);
   endfunction

   task automatic chk(string nm, logic [XLEN-1:0] act, logic [XLEN-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic [XLEN-1:0] mdl_mem [NREGS];
   logic [XLEN-1:0] mdl_rq  [NCFG][NRD];
   logic            mdl_rv  [NCFG][NRD];

   task automatic mdl_clear();
      for (int r = 0; r < NREGS; r++) mdl_mem[r] = '0;
      for (int k = 0; k < NCFG; k++)
         for (int p = 0; p < NRD; p++) begin
            mdl_rq[k][p] = '0;
            mdl_rv[k][p] = 1'b0;
         end
   endtask

   function automatic logic [XLEN-1:0] mdl_sel(int p, bit byp);
      logic [AW-1:0] ra;
      ra = raddr[p*AW +: AW];
      if (ra == 0) return '0;
      if (byp && we && (waddr == ra)) return wdata;
      return mdl_mem[ra];
   endfunction

   // Compare just before each rising edge (inputs stable, array still old),
   // then advance the model at the edge.
   initial begin
      mdl_clear();
      forever begin
         @(negedge clk);
         #4;
         if (rst) mdl_clear();
         for (int k = 0; k < NCFG; k++) begin
            for (int p = 0; p < NRD; p++) begin
               logic [XLEN-1:0] ed;
               logic            ev;
               if (cfg_lat(k)) begin
                  ed = mdl_rq[k][p];
                  ev = mdl_rv[k][p];
               end else begin
                  ed = mdl_sel(p, cfg_byp(k));
                  ev = re[p];
               end
               chk($sformatf("u%0d.rdata%0d", k, p), rd_c[k][p*XLEN +: XLEN], ed);
               chk($sformatf("u%0d.rvalid%0d", k, p), {31'b0, rv_c[k][p]}, {31'b0, ev});
            end
         end
         @(posedge clk);
         if (rst) begin
            mdl_clear();
         end else begin
            for (int k = 0; k < NCFG; k++) begin
               if (cfg_lat(k)) begin
                  for (int p = 0; p < NRD; p++) begin
                     if (re[p]) mdl_rq[k][p] = mdl_sel(p, cfg_byp(k));
                     mdl_rv[k][p] = re[p];
                  end
               end
            end
            if (we && (waddr != 0)) mdl_mem[waddr] = wdata;
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic cyc(input logic w, input logic [AW-1:0] wa, input logic [XLEN-1:0] wd,
                      input logic [NRD-1:0] r, input logic [AW-1:0] a0, input logic [AW-1:0] a1);
      @(negedge clk);
      we    = w;
      waddr = wa;
      wdata = wd;
      re    = r;
      raddr = {a1, a0};
   endtask

   initial begin
      we = 1'b0; waddr = '0; wdata = '0; re = '0; raddr = '0;
      #1 rst = 1'b1;
      // Reset state, read requests on ports 0..NRD-1
      raddr = {4'd1, 4'd0};
      re    = 2'b11;
      #2;
      for (int k = 0; k < NCFG; k++) chk($sformatf("rst.u%0d.rdata", k), rd_c[k][31:0], 32'h0);
      chk("rst.u0.rdata1", rd_c[0][63:32], 32'h0);
      chk("rst.u0.rvalid", {30'b0, rv_c[0]}, 32'h3);
      chk("rst.u3.rvalid", {30'b0, rv_c[3]}, 32'h0);
      chk("rst.u2.rvalid", {30'b0, rv_c[2]}, 32'h0);
      repeat (2) @(negedge clk);
      #1 rst = 1'b0;

      // Write 5, read it on both ports
      cyc(1'b1, 4'd5, 32'hDEADBEEF, 2'b00, 4'd0, 4'd0);
      cyc(1'b0, 4'd0, 32'h0, 2'b11, 4'd5, 4'd5);
      #3;
      chk("w5.u1.rdata0", rd_c[1][31:0],  32'hDEADBEEF);
      chk("w5.u1.rdata1", rd_c[1][63:32], 32'hDEADBEEF);
      cyc(1'b0, 4'd0, 32'h0, 2'b00, 4'd5, 4'd5);
      #3;
      chk("w5.u3.rdata0", rd_c[3][31:0],  32'hDEADBEEF);
      chk("w5.u3.rdata1", rd_c[3][63:32], 32'hDEADBEEF);
      chk("w5.u3.rvalid", {30'b0, rv_c[3]}, 32'h3);

      // Write to x0 is dropped, including in the forwarding cycle
      cyc(1'b1, 4'd0, 32'hFFFFFFFF, 2'b11, 4'd0, 4'd0);
      #3;
      chk("x0.u0.rdata0", rd_c[0][31:0],  32'h0);
      chk("x0.u0.rdata1", rd_c[0][63:32], 32'h0);
      cyc(1'b0, 4'd0, 32'h0, 2'b11, 4'd0, 4'd0);
      #3;
      chk("x0.u2.rdata0", rd_c[2][31:0], 32'h0);

      // Read/write race on index 7
      cyc(1'b1, 4'd7, 32'h11111111, 2'b00, 4'd0, 4'd0);
      cyc(1'b1, 4'd7, 32'h12345678, 2'b01, 4'd7, 4'd0);
      #3;
      chk("race.u0.rdata0", rd_c[0][31:0], 32'h12345678);
      chk("race.u1.rdata0", rd_c[1][31:0], 32'h11111111);
      cyc(1'b0, 4'd0, 32'h0, 2'b00, 4'd7, 4'd0);
      #3;
      chk("race.u2.rdata0", rd_c[2][31:0], 32'h12345678);
      chk("race.u3.rdata0", rd_c[3][31:0], 32'h11111111);

      // Registered back-to-back reads then idle
      cyc(1'b1, 4'd3, 32'd3, 2'b00, 4'd0, 4'd0);
      cyc(1'b1, 4'd4, 32'd4, 2'b00, 4'd0, 4'd0);
      cyc(1'b0, 4'd0, 32'h0, 2'b01, 4'd3, 4'd0);
      cyc(1'b0, 4'd0, 32'h0, 2'b01, 4'd4, 4'd0);
      #3;
      chk("b2b.c1.rvalid0", {31'b0, rv_c[3][0]}, 32'd1);
      chk("b2b.c1.rdata0",  rd_c[3][31:0], 32'd3);
      cyc(1'b0, 4'd0, 32'h0, 2'b00, 4'd4, 4'd0);
      #3;
      chk("b2b.c2.rvalid0", {31'b0, rv_c[3][0]}, 32'd1);
      chk("b2b.c2.rdata0",  rd_c[3][31:0], 32'd4);
      cyc(1'b0, 4'd0, 32'h0, 2'b00, 4'd4, 4'd0);
      #3;
      chk("b2b.c3.rvalid0", {31'b0, rv_c[3][0]}, 32'd0);
      chk("b2b.c3.rdata0",  rd_c[3][31:0], 32'd4);

      // Asynchronous reset between edges with a registered read pending
      cyc(1'b1, 4'd9, 32'hA5A5A5A5, 2'b00, 4'd0, 4'd0);
      cyc(1'b0, 4'd0, 32'h0, 2'b01, 4'd9, 4'd0);
      cyc(1'b0, 4'd0, 32'h0, 2'b01, 4'd9, 4'd0);
      #3;
      chk("arst.pre.u3.rdata0", rd_c[3][31:0], 32'hA5A5A5A5);
      chk("arst.pre.u1.rdata0", rd_c[1][31:0], 32'hA5A5A5A5);
      rst = 1'b1;
      #0.5;
      chk("arst.u1.rdata0",  rd_c[1][31:0], 32'h0);
      chk("arst.u3.rdata0",  rd_c[3][31:0], 32'h0);
      chk("arst.u3.rvalid0", {31'b0, rv_c[3][0]}, 32'd0);
      @(negedge clk);
      #1 rst = 1'b0;

      // Randomised traffic with frequent address collisions
      repeat (400) begin
         logic [AW-1:0] a0, a1, wa;
         wa = AW'($urandom);
         a0 = ($urandom_range(0, 2) == 0) ? wa : AW'($urandom);
         a1 = ($urandom_range(0, 2) == 0) ? wa : AW'($urandom);
         cyc(1'($urandom), wa, $urandom, NRD'($urandom), a0, a1);
      end

      cyc(1'b0, 4'd0, 32'h0, 2'b00, 4'd0, 4'd0);
      repeat (2) @(negedge clk);
      #6;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
